reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order retirement buffer for the out-of-order core, and the consuming end of the result broadcast bus driven by the reservation station (`rs_*`) and load/store buffer (`lsb_*`). Issue allocates one entry per instruction and returns its ROB id. Broadcasts mark entries complete. The head entry retires in program order as a register write, a store release, or a branch check that can flush the machine. A combinational query port supplies operand values and readiness to the issue stage.

## Interface
- `ROB_WIDTH_BIT`, default `` `ROB_WIDTH_BIT `` (4): log2 of entry count; ROB_SIZE = 1 << ROB_WIDTH_BIT.
- `clk_in` in 1: system clock; the block has a single clock.
- `rst_in` in 1: reset, synchronous and active-high.
- `rdy_in` in 1: when low, all state and all outputs hold.
- `issue_valid` in 1: allocate one entry this cycle.
- `issue_type` in 2: 0 = REG, 1 = STORE, 2 = BRANCH; 3 is treated as REG.
- `issue_rd` in 5: destination register (REG only).
- `issue_ready` in 1: result already known at issue (lui/auipc/jal link).
- `issue_value` in 32: result when `issue_ready`.
- `issue_pred_taken` in 1: predicted direction (BRANCH).
- `issue_alt_pc` in 32: redirect PC used if the branch mispredicts.
- `full` out 1: combinational; high when count == ROB_SIZE.
- `tail_id` out ROB_WIDTH_BIT: id the next accepted issue receives (the current tail).
- `q1_id`, `q2_id` in ROB_WIDTH_BIT: operand lookup ids.
- `q1_ready`, `q2_ready` out 1: combinational; the entry is complete or is being broadcast this cycle.
- `q1_value`, `q2_value` out 32: the matching value; 0 when not ready.
- `rs_ready` in 1, `rs_rob_id` in ROB_WIDTH_BIT, `rs_value` in 32: ALU result broadcast.
- `lsb_ready` in 1, `lsb_rob_id` in ROB_WIDTH_BIT, `lsb_value` in 32: load/store completion broadcast.
- `commit_valid` out 1: registered one-cycle pulse per retired entry.
- `commit_reg_we` out 1: the retired entry is REG with rd ≠ 0.
- `commit_rob_id` out ROB_WIDTH_BIT, `commit_rd` out 5, `commit_value` out 32: retired entry fields.
- `store_commit` out 1: registered pulse; the LSB may perform the store at `commit_rob_id`.
- `flush` out 1, `flush_pc` out 32: registered pulse and target on a branch mispredict.

## Operation
- Storage is a circular buffer with `head`, `tail` and `count`. Per entry: busy, ready, type, rd, value, pred_taken, alt_pc.
- Issue: when `issue_valid && !full`, the entry at `tail` is written busy=1 with ready=`issue_ready`; `tail` increments and wraps modulo ROB_SIZE. `issue_valid` while `full` is ignored, and upstream must not do this.
- Write-back: for each broadcast bus that is ready, if the busy entry matching its id is not yet ready, set ready=1 and value=bus value. RS and LSB write-backs to different ids in the same cycle both apply. RS and LSB to the same id is illegal.
- A BRANCH result is taken iff `value[0]` = 1.
- Commit, at most one per cycle: if head is busy and ready, retire it. The entry is cleared, `head` increments and `count` decrements.
  - Next-cycle outputs: `commit_valid`=1 plus the entry's fields.
  - `commit_reg_we`=(REG && rd≠0).
  - `store_commit`=STORE.
  - For BRANCH, if value[0] ≠ pred_taken: `flush`=1 and `flush_pc`=alt_pc.
- Mispredict retire: at the same edge, every entry's busy bit clears and head=tail=count=0. Any issue in that cycle is discarded.
- Simultaneous issue and commit keep `count` unchanged. Issue into the slot being freed is legal when the buffer was full.
- Query: `qN_ready` = (entry busy && ready) || (rs_ready && rs_rob_id==qN_id) || (lsb_ready && lsb_rob_id==qN_id). Value priority is stored value, then RS, then LSB.

## Timing
- Reset values: head, tail and count are 0, and all busy bits are 0. Every registered output (commit_*, store_commit, flush, flush_pc) is 0. `full`=0 and `tail_id`=0.
- Issue at edge E0 with `issue_ready`=1: the earliest retire is edge E1, with `commit_valid` high in the cycle after E1.
- Broadcast at edge Ew: the entry becomes ready at Ew and can retire at Ew+1 at the earliest. There is no same-edge broadcast-to-commit bypass.
- Throughput is 1 issue and 1 commit per cycle sustained.
- `flush` is high for exactly one cycle. During that cycle the ROB is already empty, `tail_id`=0, and `issue_valid` is ignored.
- Reset mid-operation discards all entries. No commit or flush pulse is produced afterwards.

## Test plan
- Reset, then issue 3 REG entries rd=1,2,3 with `issue_ready`=0 → `tail_id` reads 0, 1, 2, 3. Broadcast RS id 1 value 0x22, then id 0 value 0x11 → retires id 0 (rd1=0x11) then id 1 (rd2=0x22) on consecutive cycles. Id 2 does not retire.
- Fill all 16 entries → `full`=1 and a 17th issue is ignored. Make head ready, then issue in the cycle it retires → count stays 16 and `tail_id` wraps 0→1.
- Same cycle: RS broadcasts id 4 = 5 and LSB broadcasts id 5 = 7. `q1_id`=4 and `q2_id`=5 → both ready with values 5 and 7 combinationally. Both entries are later retired with those values.
- Issue BRANCH with pred_taken=0 and alt_pc=0x100, followed by 2 REG entries. Broadcast RS value 1 for the branch → `flush`=1 and `flush_pc`=0x100 for one cycle. The REG entries never commit, and `tail_id`=0 afterwards.
- Correct BRANCH (pred 1, value 1) and a STORE → `commit_valid` with `commit_reg_we`=0 and no flush. The STORE produces `store_commit`=1 with its id. A REG with rd=0 gives `commit_reg_we`=0.
- Hold `rdy_in` low across a pending broadcast → no state or output change. Assert `rst_in` with 5 entries live → empty and all outputs 0 on the next cycle.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer. Issue allocates at the
// tail, RS/LSB broadcasts complete entries, the head retires one entry per
// cycle as a register write, a store release or a branch check that flushes.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = `ROB_WIDTH_BIT
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    input  logic [1:0]               issue_type,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_ready,
    input  logic [31:0]              issue_value,
    input  logic                     issue_pred_taken,
    input  logic [31:0]              issue_alt_pc,
    output logic                     full,
    output logic [ROB_WIDTH_BIT-1:0] tail_id,
    input  logic [ROB_WIDTH_BIT-1:0] q1_id,
    input  logic [ROB_WIDTH_BIT-1:0] q2_id,
    output logic                     q1_ready,
    output logic                     q2_ready,
    output logic [31:0]              q1_value,
    output logic [31:0]              q2_value,
    input  logic                     rs_ready,
    input  logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
    input  logic [31:0]              rs_value,
    input  logic                     lsb_ready,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
    input  logic [31:0]              lsb_value,
    output logic                     commit_valid,
    output logic                     commit_reg_we,
    output logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    output logic [4:0]               commit_rd,
    output logic [31:0]              commit_value,
    output logic                     store_commit,
    output logic                     flush,
    output logic [31:0]              flush_pc
);
    localparam int ROB_SIZE = 1 << ROB_WIDTH_BIT;
    localparam int CNT_W    = ROB_WIDTH_BIT + 1;

    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;

    // Entry storage
    logic        busy_q  [ROB_SIZE];
    logic        busy_d  [ROB_SIZE];
    logic        ready_q [ROB_SIZE];
    logic        ready_d [ROB_SIZE];
    logic [1:0]  type_q  [ROB_SIZE];
    logic [1:0]  type_d  [ROB_SIZE];
    logic [4:0]  rd_q    [ROB_SIZE];
    logic [4:0]  rd_d    [ROB_SIZE];
    logic [31:0] value_q [ROB_SIZE];
    logic [31:0] value_d [ROB_SIZE];
    logic        pred_q  [ROB_SIZE];
    logic        pred_d  [ROB_SIZE];
    logic [31:0] alt_q   [ROB_SIZE];
    logic [31:0] alt_d   [ROB_SIZE];

    logic [ROB_WIDTH_BIT-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic                     commit_valid_q, commit_valid_d;
    logic                     commit_reg_we_q, commit_reg_we_d;
    logic [ROB_WIDTH_BIT-1:0] commit_rob_id_q, commit_rob_id_d;
    logic [4:0]               commit_rd_q, commit_rd_d;
    logic [31:0]              commit_value_q, commit_value_d;
    logic                     store_commit_q, store_commit_d;
    logic                     flush_q, flush_d;
    logic [31:0]              flush_pc_q, flush_pc_d;

    logic commit_fire, mispredict, issue_fire, head_is_reg;

    assign full          = (count_q == CNT_W'(ROB_SIZE));
    assign tail_id       = tail_q;
    assign commit_valid  = commit_valid_q;
    assign commit_reg_we = commit_reg_we_q;
    assign commit_rob_id = commit_rob_id_q;
    assign commit_rd     = commit_rd_q;
    assign commit_value  = commit_value_q;
    assign store_commit  = store_commit_q;
    assign flush         = flush_q;
    assign flush_pc      = flush_pc_q;

    // Operand query: stored result first, then the RS bus, then the LSB bus.
    always_comb begin
        q1_ready = 1'b0;
        q1_value = 32'd0;
        q2_ready = 1'b0;
        q2_value = 32'd0;
        if (busy_q[q1_id] && ready_q[q1_id]) begin
            q1_ready = 1'b1;
            q1_value = value_q[q1_id];
        end else if (rs_ready && rs_rob_id == q1_id) begin
            q1_ready = 1'b1;
            q1_value = rs_value;
        end else if (lsb_ready && lsb_rob_id == q1_id) begin
            q1_ready = 1'b1;
            q1_value = lsb_value;
        end
        if (busy_q[q2_id] && ready_q[q2_id]) begin
            q2_ready = 1'b1;
            q2_value = value_q[q2_id];
        end else if (rs_ready && rs_rob_id == q2_id) begin
            q2_ready = 1'b1;
            q2_value = rs_value;
        end else if (lsb_ready && lsb_rob_id == q2_id) begin
            q2_ready = 1'b1;
            q2_value = lsb_value;
        end
    end

    // Next-state: write-back, retire at head, allocate at tail, flush on mispredict.
    // Issue handshake: an issue is taken when issue_valid is high, no flush pulse
    // is out, no mispredict retires this edge, and the buffer is not full or the
    // head retires at the same edge; otherwise the request is dropped (not stalled).
    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        type_d  = type_q;
        rd_d    = rd_q;
        value_d = value_q;
        pred_d  = pred_q;
        alt_d   = alt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        commit_valid_d  = commit_valid_q;
        commit_reg_we_d = commit_reg_we_q;
        commit_rob_id_d = commit_rob_id_q;
        commit_rd_d     = commit_rd_q;
        commit_value_d  = commit_value_q;
        store_commit_d  = store_commit_q;
        flush_d         = flush_q;
        flush_pc_d      = flush_pc_q;
        commit_fire = 1'b0;
        mispredict  = 1'b0;
        issue_fire  = 1'b0;
        head_is_reg = (type_q[head_q] != TYPE_STORE) && (type_q[head_q] != TYPE_BRANCH);
        if (rdy_in) begin
            commit_valid_d  = 1'b0;
            commit_reg_we_d = 1'b0;
            store_commit_d  = 1'b0;
            flush_d         = 1'b0;
            commit_fire = busy_q[head_q] && ready_q[head_q];
            mispredict  = commit_fire && (type_q[head_q] == TYPE_BRANCH) &&
                          (value_q[head_q][0] != pred_q[head_q]);
            issue_fire  = issue_valid && !flush_q && !mispredict && (!full || commit_fire);

            if (rs_ready && busy_q[rs_rob_id] && !ready_q[rs_rob_id]) begin
                ready_d[rs_rob_id] = 1'b1;
                value_d[rs_rob_id] = rs_value;
            end
            if (lsb_ready && busy_q[lsb_rob_id] && !ready_q[lsb_rob_id]) begin
                ready_d[lsb_rob_id] = 1'b1;
                value_d[lsb_rob_id] = lsb_value;
            end

            if (commit_fire) begin
                commit_valid_d  = 1'b1;
                commit_reg_we_d = head_is_reg && (rd_q[head_q] != 5'd0);
                commit_rob_id_d = head_q;
                commit_rd_d     = rd_q[head_q];
                commit_value_d  = value_q[head_q];
                store_commit_d  = (type_q[head_q] == TYPE_STORE);
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + ROB_WIDTH_BIT'(1);
            end

            // Issue after retire so a full buffer can refill the slot just freed.
            if (issue_fire) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = issue_ready;
                type_d[tail_q]  = issue_type;
                rd_d[tail_q]    = issue_rd;
                value_d[tail_q] = issue_ready ? issue_value : 32'd0;
                pred_d[tail_q]  = issue_pred_taken;
                alt_d[tail_q]   = issue_alt_pc;
                tail_d          = tail_q + ROB_WIDTH_BIT'(1);
            end

            if (issue_fire && !commit_fire) begin
                count_d = count_q + CNT_W'(1);
            end else if (commit_fire && !issue_fire) begin
                count_d = count_q - CNT_W'(1);
            end

            if (mispredict) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    busy_d[i]  = 1'b0;
                    ready_d[i] = 1'b0;
                end
                head_d     = '0;
                tail_d     = '0;
                count_d    = '0;
                flush_d    = 1'b1;
                flush_pc_d = alt_q[head_q];
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
                type_q[i]  <= 2'd0;
                rd_q[i]    <= 5'd0;
                value_q[i] <= 32'd0;
                pred_q[i]  <= 1'b0;
                alt_q[i]   <= 32'd0;
            end
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commit_valid_q  <= 1'b0;
            commit_reg_we_q <= 1'b0;
            commit_rob_id_q <= '0;
            commit_rd_q     <= 5'd0;
            commit_value_q  <= 32'd0;
            store_commit_q  <= 1'b0;
            flush_q         <= 1'b0;
            flush_pc_q      <= 32'd0;
        end else begin
            busy_q          <= busy_d;
            ready_q         <= ready_d;
            type_q          <= type_d;
            rd_q            <= rd_d;
            value_q         <= value_d;
            pred_q          <= pred_d;
            alt_q           <= alt_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_valid_q  <= commit_valid_d;
            commit_reg_we_q <= commit_reg_we_d;
            commit_rob_id_q <= commit_rob_id_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
            store_commit_q  <= store_commit_d;
            flush_q         <= flush_d;
            flush_pc_q      <= flush_pc_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed vector table plus hand-written sequences for
// wrap, flush, store/branch retire, rdy_in stall and mid-run reset.
module tb_reorder_buffer;
    localparam int W  = 4;
    localparam int EW = W + 5 + 1 + 1 + 32;

    logic         clk_in = 1'b0;
    logic         rst_in, rdy_in;
    logic         issue_valid, issue_ready, issue_pred_taken;
    logic [1:0]   issue_type;
    logic [4:0]   issue_rd;
    logic [31:0]  issue_value, issue_alt_pc;
    logic         full;
    logic [W-1:0] tail_id, q1_id, q2_id;
    logic         q1_ready, q2_ready;
    logic [31:0]  q1_value, q2_value;
    logic         rs_ready, lsb_ready;
    logic [W-1:0] rs_rob_id, lsb_rob_id;
    logic [31:0]  rs_value, lsb_value;
    logic         commit_valid, commit_reg_we, store_commit, flush;
    logic [W-1:0] commit_rob_id;
    logic [4:0]   commit_rd;
    logic [31:0]  commit_value, flush_pc;

    int checks = 0;
    int errors = 0;
    int flush_cnt = 0;
    logic [EW-1:0] exp_q[$];

    reorder_buffer #(.ROB_WIDTH_BIT(W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .issue_value(issue_value),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .full(full), .tail_id(tail_id),
        .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_value(q1_value), .q2_value(q2_value),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .commit_valid(commit_valid), .commit_reg_we(commit_reg_we),
        .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
        .commit_value(commit_value), .store_commit(store_commit),
        .flush(flush), .flush_pc(flush_pc)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic         iv;
        logic [4:0]   rd;
        logic         ir;
        logic [31:0]  ival;
        logic         rsv;
        logic [W-1:0] rsid;
        logic [31:0]  rsval;
        logic         lv;
        logic [W-1:0] lid;
        logic [31:0]  lval;
        logic [W-1:0] q1, q2;
        logic         e_full;
        logic [W-1:0] e_tail;
        logic         e_q1r;
        logic [31:0]  e_q1v;
        logic         e_q2r;
        logic [31:0]  e_q2v;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mkv(logic iv, logic [4:0] rd, logic ir, logic [31:0] ival,
                                 logic rsv, logic [W-1:0] rsid, logic [31:0] rsval,
                                 logic lv, logic [W-1:0] lid, logic [31:0] lval,
                                 logic [W-1:0] q1, logic [W-1:0] q2, logic [W-1:0] e_tail,
                                 logic e_q1r, logic [31:0] e_q1v,
                                 logic e_q2r, logic [31:0] e_q2v);
        vec_t v;
        v.iv = iv; v.rd = rd; v.ir = ir; v.ival = ival;
        v.rsv = rsv; v.rsid = rsid; v.rsval = rsval;
        v.lv = lv; v.lid = lid; v.lval = lval;
        v.q1 = q1; v.q2 = q2; v.e_full = 1'b0; v.e_tail = e_tail;
        v.e_q1r = e_q1r; v.e_q1v = e_q1v; v.e_q2r = e_q2r; v.e_q2v = e_q2v;
        return v;
    endfunction

    function automatic logic [EW-1:0] crec(logic [W-1:0] id, logic [4:0] rd, logic we,
                                           logic st, logic [31:0] val);
        return {id, rd, we, st, val};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_idle();
        issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_ready = 1'b0;
        issue_value = 32'd0; issue_pred_taken = 1'b0; issue_alt_pc = 32'd0;
        rs_ready = 1'b0; rs_rob_id = '0; rs_value = 32'd0;
        lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = 32'd0;
    endtask

    task automatic drive_issue(input logic [1:0] t, input logic [4:0] rd, input logic r,
                               input logic [31:0] val, input logic pred, input logic [31:0] alt);
        issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_ready = r;
        issue_value = val; issue_pred_taken = pred; issue_alt_pc = alt;
    endtask

    task automatic do_reset();
        set_idle();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_commit_valid"}, 32'(commit_valid), 32'd0);
        check({tag, "_commit_reg_we"}, 32'(commit_reg_we), 32'd0);
        check({tag, "_commit_rob_id"}, 32'(commit_rob_id), 32'd0);
        check({tag, "_commit_rd"}, 32'(commit_rd), 32'd0);
        check({tag, "_commit_value"}, commit_value, 32'd0);
        check({tag, "_store_commit"}, 32'(store_commit), 32'd0);
        check({tag, "_flush"}, 32'(flush), 32'd0);
        check({tag, "_flush_pc"}, flush_pc, 32'd0);
        check({tag, "_tail_id"}, 32'(tail_id), 32'd0);
        check({tag, "_full"}, 32'(full), 32'd0);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            set_idle();
            if (vecs[i].iv) drive_issue(2'd0, vecs[i].rd, vecs[i].ir, vecs[i].ival, 1'b0, 32'd0);
            rs_ready = vecs[i].rsv; rs_rob_id = vecs[i].rsid; rs_value = vecs[i].rsval;
            lsb_ready = vecs[i].lv; lsb_rob_id = vecs[i].lid; lsb_value = vecs[i].lval;
            q1_id = vecs[i].q1; q2_id = vecs[i].q2;
            #1;
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            check($sformatf("vec%0d_tail_id", i), 32'(tail_id), 32'(vecs[i].e_tail));
            check($sformatf("vec%0d_q1_ready", i), 32'(q1_ready), 32'(vecs[i].e_q1r));
            check($sformatf("vec%0d_q1_value", i), q1_value, vecs[i].e_q1v);
            check($sformatf("vec%0d_q2_ready", i), 32'(q2_ready), 32'(vecs[i].e_q2r));
            check($sformatf("vec%0d_q2_value", i), q2_value, vecs[i].e_q2v);
            tick();
        end
        set_idle();
    endtask

    // Scoreboard: every retire must match the head of the expected queue.
    always @(negedge clk_in) begin
        if (!rst_in && commit_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_commit got id %0d rd %0d value %h want none",
                         commit_rob_id, commit_rd, commit_value);
            end else begin
                logic [EW-1:0] want;
                logic [EW-1:0] got;
                want = exp_q.pop_front();
                got  = {commit_rob_id, commit_rd, commit_reg_we, store_commit, commit_value};
                if (got !== want) begin
                    errors++;
                    $display("FAIL commit got %h want %h", got, want);
                end
            end
        end
        if (!rst_in && flush) flush_cnt++;
    end

    initial begin
        rdy_in = 1'b1;
        q1_id = '0;
        q2_id = '0;
        set_idle();

        // Vectors 0-7: three REG issues, out-of-order broadcasts, in-order retire.
        vecs.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 1, 1, 32'h22, 0, 0, 0, 1, 0, 3, 1, 32'h22, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 1, 0, 32'h11, 0, 0, 0, 1, 0, 3, 1, 32'h22, 1, 32'h11));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 3, 0, 0, 1, 32'h11));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 3, 0, 0, 1, 32'h22));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 3, 0, 0, 0, 0));
        // Vectors 8-17: four ready issues retire, then dual RS/LSB broadcast to ids 4/5.
        for (int i = 0; i < 4; i++)
            vecs.push_back(mkv(1, 5'(10 + i), 1, 32'hA0 + i, 0, 0, 0, 0, 0, 0, 4, 5, 4'(i), 0, 0, 0, 0));
        vecs.push_back(mkv(1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 4, 0, 0, 0, 0));
        vecs.push_back(mkv(1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 5, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 1, 4, 5, 1, 5, 7, 4, 5, 6, 1, 5, 1, 7));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 6, 1, 5, 1, 7));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 6, 0, 0, 1, 7));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 6, 0, 0, 0, 0));

        // Reset state
        do_reset();
        check_zero_outputs("reset");

        exp_q.push_back(crec(0, 1, 1, 0, 32'h11));
        exp_q.push_back(crec(1, 2, 1, 0, 32'h22));
        run_vecs(0, 7);
        do_reset();
        check_zero_outputs("reset2");

        for (int i = 0; i < 4; i++) exp_q.push_back(crec(4'(i), 5'(10 + i), 1, 0, 32'hA0 + i));
        exp_q.push_back(crec(4, 14, 1, 0, 32'd5));
        exp_q.push_back(crec(5, 15, 1, 0, 32'd7));
        run_vecs(8, 17);

        // Fill to 16 entries, drop a 17th, then refill the slot being retired.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_issue(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b0, 32'd0);
            #1;
            check($sformatf("fill_tail_%0d", i), 32'(tail_id), i);
            tick();
        end
        set_idle();
        check("fill_full", 32'(full), 32'd1);
        check("fill_tail_wrap", 32'(tail_id), 32'd0);
        drive_issue(2'd0, 5'd31, 1'b1, 32'hBAD, 1'b0, 32'd0);
        tick();
        set_idle();
        check("ignored17_tail", 32'(tail_id), 32'd0);
        check("ignored17_full", 32'(full), 32'd1);
        exp_q.push_back(crec(0, 1, 1, 0, 32'h55));
        rs_ready = 1'b1; rs_rob_id = 4'd0; rs_value = 32'h55;
        tick();
        set_idle();
        drive_issue(2'd0, 5'd20, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        set_idle();
        check("refill_tail", 32'(tail_id), 32'd1);
        check("refill_full", 32'(full), 32'd1);
        tick();

        // Branch mispredict flushes younger entries.
        do_reset();
        exp_q.push_back(crec(0, 0, 0, 0, 32'd1));
        drive_issue(2'd2, 5'd0, 1'b0, 32'd0, 1'b0, 32'h100);
        tick();
        drive_issue(2'd0, 5'd5, 1'b1, 32'd9, 1'b0, 32'd0);
        tick();
        drive_issue(2'd0, 5'd6, 1'b1, 32'd10, 1'b0, 32'd0);
        tick();
        set_idle();
        rs_ready = 1'b1; rs_rob_id = 4'd0; rs_value = 32'd1;
        tick();
        set_idle();
        tick();
        check("flush_pulse", 32'(flush), 32'd1);
        check("flush_pc", flush_pc, 32'h100);
        check("flush_tail", 32'(tail_id), 32'd0);
        check("flush_full", 32'(full), 32'd0);
        drive_issue(2'd0, 5'd7, 1'b1, 32'd3, 1'b0, 32'd0);
        tick();
        set_idle();
        check("flush_one_cycle", 32'(flush), 32'd0);
        check("flush_issue_ignored", 32'(tail_id), 32'd0);
        repeat (4) tick();

        // Correct branch, store and rd=0 REG retire without register write or flush.
        exp_q.push_back(crec(0, 0, 0, 0, 32'd1));
        exp_q.push_back(crec(1, 0, 0, 1, 32'hDEAD));
        exp_q.push_back(crec(2, 0, 0, 0, 32'h33));
        drive_issue(2'd2, 5'd0, 1'b0, 32'd0, 1'b1, 32'h200);
        tick();
        drive_issue(2'd1, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        drive_issue(2'd0, 5'd0, 1'b1, 32'h33, 1'b0, 32'd0);
        tick();
        set_idle();
        rs_ready = 1'b1; rs_rob_id = 4'd0; rs_value = 32'd1;
        lsb_ready = 1'b1; lsb_rob_id = 4'd1; lsb_value = 32'hDEAD;
        tick();
        set_idle();
        repeat (5) tick();
        check("flush_count", flush_cnt, 1);

        // rdy_in low freezes state even with a broadcast and an issue pending.
        drive_issue(2'd0, 5'd7, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        set_idle();
        rdy_in = 1'b0;
        rs_ready = 1'b1; rs_rob_id = 4'd3; rs_value = 32'h77;
        issue_valid = 1'b1; issue_rd = 5'd8;
        q1_id = 4'd3;
        #1;
        check("stall_q1_bypass_ready", 32'(q1_ready), 32'd1);
        check("stall_q1_bypass_value", q1_value, 32'h77);
        tick();
        tick();
        check("stall_tail", 32'(tail_id), 32'd4);
        check("stall_commit_valid", 32'(commit_valid), 32'd0);
        set_idle();
        #1;
        check("stall_entry_not_ready", 32'(q1_ready), 32'd0);
        rdy_in = 1'b1;
        tick();
        check("resume_entry_not_ready", 32'(q1_ready), 32'd0);
        check("resume_tail", 32'(tail_id), 32'd4);
        exp_q.push_back(crec(3, 7, 1, 0, 32'h88));
        rs_ready = 1'b1; rs_rob_id = 4'd3; rs_value = 32'h88;
        tick();
        set_idle();
        repeat (3) tick();

        // Reset with five live entries and a broadcast on the head.
        for (int i = 0; i < 5; i++) begin
            drive_issue(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b0, 32'd0);
            tick();
        end
        set_idle();
        rst_in = 1'b1;
        rs_ready = 1'b1; rs_rob_id = 4'd4; rs_value = 32'h99;
        tick();
        rst_in = 1'b0;
        set_idle();
        q1_id = 4'd4;
        #1;
        check_zero_outputs("midreset");
        check("midreset_q1_ready", 32'(q1_ready), 32'd0);
        repeat (5) tick();

        check("pending_commits", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
